energy_scan_ctrl: RTL and testbench
===================================

Name: energy_scan_ctrl

Overview:
- Sequencer and accumulator that drives a combinational N-to-1 spin vector mux in the energy monitor, and consumes its output.
- Accepts one spin vector per valve/ready transaction and registers it onto the mux data input.
- Steps the mux index from 0 to DATAWIDTH-1, one index per cycle.
- Per cycle, accumulates +w if the selected spin bit is 1, or -w if it is 0.
- Returns the signed energy sum over a valid/ready output handshake.

Parameters:
- DATAWIDTH, 256, number of spins per vector (must be >= 2).
- IDX_BIT, $clog2(DATAWIDTH), width of the mux index.
- WEIGHT_W, 8, width of the signed two's-complement per-spin weight.
- ACC_W, WEIGHT_W+IDX_BIT+1, width of the signed accumulator and energy output.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous abort; returns to IDLE and discards the scan.
- spin_valid_i  input  1  upstream spin vector valid.
- spin_ready_o  output  1  block can accept a spin vector.
- spin_i  input  DATAWIDTH  upstream spin vector.
- mux_en_o  output  1  drives the mux enable.
- mux_data_o  output  DATAWIDTH  registered spin vector; drives the mux data input.
- mux_idx_o  output  IDX_BIT  current scan index; drives the mux index.
- mux_bit_i  input  1  selected spin bit returned by the mux, same cycle.
- weight_i  input  WEIGHT_W  signed weight for mux_idx_o; combinational from the weight store, valid in the same cycle.
- energy_valid_o  output  1  energy result valid.
- energy_ready_i  input  1  downstream accepts the result.
- energy_o  output  ACC_W  signed accumulated energy.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - state=IDLE.
  - spin_ready_o=1; mux_en_o=0; energy_valid_o=0.
  - mux_data_o=0; mux_idx_o=0; energy_o=0; accumulator=0.
- FSM states are IDLE, SCAN and DONE. Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- IDLE:
  - spin_ready_o=1, mux_en_o=0, energy_valid_o=0.
  - On spin_valid_i & spin_ready_o: mux_data_o<=spin_i, mux_idx_o<=0, accumulator<=0, go to SCAN.
- SCAN:
  - spin_ready_o=0, mux_en_o=1.
  - Each cycle: accumulator <= accumulator + (mux_bit_i ? sext(weight_i) : -sext(weight_i)), computed in ACC_W bits.
  - When mux_idx_o==DATAWIDTH-1: perform the final add, go to DONE, leave mux_idx_o at 0. Otherwise mux_idx_o<=mux_idx_o+1.
- DONE:
  - energy_valid_o=1, energy_o=accumulator, mux_en_o=0, spin_ready_o=0.
  - energy_o and energy_valid_o stay stable until energy_ready_i=1.
  - On energy_ready_i=1, go to IDLE the next cycle.
  - A new spin vector is not accepted in the same cycle the result is accepted.
- Latency: handshake accepted at cycle T; scan runs at cycles T+1..T+DATAWIDTH; energy_valid_o=1 from cycle T+DATAWIDTH+1. Throughput is one vector per DATAWIDTH+2 cycles minimum.
- Arithmetic:
  - Negation and sign-extension happen before the add.
  - -(-2^(WEIGHT_W-1)) is representable because ACC_W > WEIGHT_W.
  - The default ACC_W is overflow-free.
  - A smaller ACC_W override wraps in two's complement; there is no saturation.
- energy_o holds its last value in IDLE and SCAN; only energy_valid_o qualifies it.
- clear_i has priority over every transition, in any state. Next cycle: IDLE, accumulator=0, mux_idx_o=0, energy_valid_o=0. mux_data_o is retained.
- clear_i takes priority over a simultaneous spin handshake; the vector is not taken.
- spin_valid_i in SCAN or DONE is ignored (ready=0); upstream must hold it.
- rst_i asserted mid-scan forces the reset values immediately. The partial sum is lost.

Test Plan:
- DATAWIDTH=8, spin_i=8'hFF, all weights +3 → energy_valid_o high at T+9, energy_o=+24.
- DATAWIDTH=8, spin_i=8'h00, all weights -128 → energy_o=+1024. Checks negation of the most negative weight.
- DATAWIDTH=8, spin_i=8'b1010_0101, weight[k]=k (0..7) → energy_o=(0+2+5+7)-(1+3+4+6)=0. Also check that mux_idx_o steps 0..7 with mux_en_o=1 for exactly 8 cycles.
- Result ready, energy_ready_i held low for 5 cycles → energy_o and energy_valid_o stay stable and spin_ready_o stays 0. On ready=1, IDLE next cycle and spin_ready_o=1.
- clear_i pulsed at scan index 4 → next cycle IDLE, mux_en_o=0. No energy_valid_o; a following vector yields a correct fresh sum.
- rst_i asserted asynchronously mid-scan, between edges → all outputs at reset values before the next edge. spin_valid_i held in SCAN is not consumed until IDLE.

Source files
------------

// File: rtl/energy_scan_ctrl.sv
// Takes one spin vector, steps the mux index 0..DATAWIDTH-1 and sums +/-weight per spin bit.
// Result valid DATAWIDTH+1 cycles after input accept; result held until energy_ready_i, no input accepted meanwhile.
module energy_scan_ctrl #(
    parameter int DATAWIDTH = 256,
    parameter int IDX_BIT   = $clog2(DATAWIDTH),
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = WEIGHT_W + IDX_BIT + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 spin_valid_i,
    output logic                 spin_ready_o,
    input  logic [DATAWIDTH-1:0] spin_i,
    output logic                 mux_en_o,
    output logic [DATAWIDTH-1:0] mux_data_o,
    output logic [IDX_BIT-1:0]   mux_idx_o,
    input  logic                 mux_bit_i,
    input  logic [WEIGHT_W-1:0]  weight_i,
    output logic                 energy_valid_o,
    input  logic                 energy_ready_i,
    output logic [ACC_W-1:0]     energy_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   data_q, data_d;
    logic [IDX_BIT-1:0]     idx_q, idx_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       energy_q, energy_d;
    logic [ACC_W-1:0]       w_ext;
    logic [ACC_W-1:0]       addend;
    logic [ACC_W-1:0]       acc_sum;
    logic                   last_idx;

    // Sign-extend first so negating the most negative weight cannot overflow.
    assign w_ext    = {{(ACC_W-WEIGHT_W){weight_i[WEIGHT_W-1]}}, weight_i};
    assign addend   = mux_bit_i ? w_ext : (~w_ext + 1'b1);
    assign acc_sum  = acc_q + addend;
    assign last_idx = (idx_q == IDX_BIT'(DATAWIDTH-1));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        energy_d = energy_q;
        if (clear_i) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (spin_valid_i) begin
                        data_d  = spin_i;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    acc_d = acc_sum;
                    if (last_idx) begin
                        idx_d    = '0;
                        energy_d = acc_sum;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (energy_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            energy_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
        end
    end

    assign spin_ready_o   = (state_q == IDLE);
    assign mux_en_o       = (state_q == SCAN);
    assign energy_valid_o = (state_q == DONE);
    assign mux_data_o     = data_q;
    assign mux_idx_o      = idx_q;
    assign energy_o       = energy_q;

endmodule

// File: tb/tb_energy_scan_ctrl.sv
// Bench for energy_scan_ctrl at DATAWIDTH=8: directed vector table, hand sequences, random vectors vs arithmetic model.
module tb_energy_scan_ctrl;

    localparam int DW    = 8;
    localparam int IB    = 3;
    localparam int WW    = 8;
    localparam int AW    = WW + IB + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          spin_valid_i;
    logic          spin_ready_o;
    logic [DW-1:0] spin_i;
    logic          mux_en_o;
    logic [DW-1:0] mux_data_o;
    logic [IB-1:0] mux_idx_o;
    logic          mux_bit_i;
    logic [WW-1:0] weight_i;
    logic          energy_valid_o;
    logic          energy_ready_i;
    logic [AW-1:0] energy_o;

    logic [WW-1:0] wtab [DW];
    logic [AW-1:0] last_energy;
    int            errs   = 0;
    int            checks = 0;

    typedef struct {
        logic [DW-1:0]    spin;
        logic [DW*WW-1:0] w;
        logic [AW-1:0]    exp;
        int               hold;
    } vec_t;

    vec_t tbl [5];

    energy_scan_ctrl #(.DATAWIDTH(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .spin_valid_i   (spin_valid_i),
        .spin_ready_o   (spin_ready_o),
        .spin_i         (spin_i),
        .mux_en_o       (mux_en_o),
        .mux_data_o     (mux_data_o),
        .mux_idx_o      (mux_idx_o),
        .mux_bit_i      (mux_bit_i),
        .weight_i       (weight_i),
        .energy_valid_o (energy_valid_o),
        .energy_ready_i (energy_ready_i),
        .energy_o       (energy_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational mux and weight store the block drives.
    assign mux_bit_i = mux_data_o[mux_idx_o];
    assign weight_i  = wtab[mux_idx_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ref_energy(input logic [DW-1:0] s, input logic [DW*WW-1:0] w);
        int sum = 0;
        logic signed [WW-1:0] b;
        for (int k = 0; k < DW; k++) begin
            b = w[WW*k +: WW];
            sum += s[k] ? int'(b) : -int'(b);
        end
        return AW'(sum);
    endfunction

    task automatic load_w(input logic [DW*WW-1:0] w);
        for (int k = 0; k < DW; k++) wtab[k] = w[WW*k +: WW];
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   64'(spin_ready_o),   64'd1);
        chk({tag, "_en"},    64'(mux_en_o),       64'd0);
        chk({tag, "_vld"},   64'(energy_valid_o), 64'd0);
        chk({tag, "_data"},  64'(mux_data_o),     64'd0);
        chk({tag, "_idx"},   64'(mux_idx_o),      64'd0);
        chk({tag, "_energy"},64'(energy_o),       64'd0);
    endtask

    // Full transaction: accept, 8 scan cycles, result at T+9, optional backpressure, then ack.
    task automatic do_scan(input logic [DW-1:0] s, input logic [DW*WW-1:0] w,
                           input logic [AW-1:0] exp, input int hold);
        @(negedge clk_i);
        chk("accept_rdy", 64'(spin_ready_o), 64'd1);
        spin_valid_i = 1'b1;
        spin_i       = s;
        load_w(w);
        @(negedge clk_i);
        spin_valid_i = 1'b0;
        for (int i = 0; i < DW; i++) begin
            chk("scan_en",    64'(mux_en_o),       64'd1);
            chk("scan_idx",   64'(mux_idx_o),      64'(i));
            chk("scan_rdy",   64'(spin_ready_o),   64'd0);
            chk("scan_vld",   64'(energy_valid_o), 64'd0);
            chk("scan_ehold", 64'(energy_o),       64'(last_energy));
            if (i < DW-1) @(negedge clk_i);
        end
        @(negedge clk_i);
        chk("done_vld",    64'(energy_valid_o), 64'd1);
        chk("done_energy", 64'(energy_o),       64'(exp));
        chk("done_en",     64'(mux_en_o),       64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            chk("bp_vld",    64'(energy_valid_o), 64'd1);
            chk("bp_energy", 64'(energy_o),       64'(exp));
            chk("bp_rdy",    64'(spin_ready_o),   64'd0);
        end
        energy_ready_i = 1'b1;
        @(negedge clk_i);
        energy_ready_i = 1'b0;
        chk("ack_rdy",   64'(spin_ready_o),   64'd1);
        chk("ack_vld",   64'(energy_valid_o), 64'd0);
        chk("ack_ehold", 64'(energy_o),       64'(exp));
        last_energy = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0]    s;
        logic [DW*WW-1:0] w;

        tbl[0] = '{8'hFF, {8{8'h03}}, 12'd24, 5};
        tbl[1] = '{8'h00, {8{8'h80}}, 12'h400, 0};
        tbl[2] = '{8'hA5, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 12'd0, 1};
        tbl[3] = '{8'h01, {8{8'h7F}}, 12'hD06, 0};
        tbl[4] = '{8'h80, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 12'hFF2, 2};

        rst_i = 1'b1; clear_i = 1'b0; spin_valid_i = 1'b0; spin_i = '0; energy_ready_i = 1'b0;
        load_w('0);
        last_energy = '0;
        #3;
        chk_reset_vals("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) do_scan(tbl[i].spin, tbl[i].w, tbl[i].exp, tbl[i].hold);

        // Upstream holds valid through a scan: not taken until the IDLE cycle after the ack.
        @(negedge clk_i);
        spin_valid_i = 1'b1;
        spin_i       = 8'hFF;
        load_w({8{8'h01}});
        @(negedge clk_i);
        spin_i = 8'h07;
        for (int i = 0; i < DW; i++) begin
            chk("hold_data", 64'(mux_data_o), 64'hFF);
            chk("hold_idx",  64'(mux_idx_o),  64'(i));
            @(negedge clk_i);
        end
        chk("hold_vld",    64'(energy_valid_o), 64'd1);
        chk("hold_energy", 64'(energy_o),       64'd8);
        chk("hold_rdy",    64'(spin_ready_o),   64'd0);
        energy_ready_i = 1'b1;
        @(negedge clk_i);
        chk("hold_idle_rdy",  64'(spin_ready_o), 64'd1);
        chk("hold_idle_en",   64'(mux_en_o),     64'd0);
        chk("hold_idle_data", 64'(mux_data_o),   64'hFF);
        @(negedge clk_i);
        energy_ready_i = 1'b0;
        spin_valid_i   = 1'b0;
        chk("hold_take_en",   64'(mux_en_o),   64'd1);
        chk("hold_take_data", 64'(mux_data_o), 64'h07);
        chk("hold_take_ehold",64'(energy_o),   64'd8);
        repeat (DW) @(negedge clk_i);
        chk("hold2_vld",    64'(energy_valid_o), 64'd1);
        chk("hold2_energy", 64'(energy_o),       64'hFFE);
        energy_ready_i = 1'b1;
        @(negedge clk_i);
        energy_ready_i = 1'b0;
        last_energy = 12'hFFE;

        // Abort at scan index 4.
        @(negedge clk_i);
        spin_valid_i = 1'b1;
        spin_i       = 8'hAA;
        load_w({8{8'h05}});
        @(negedge clk_i);
        spin_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("clr_at_idx", 64'(mux_idx_o), 64'd4);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_rdy",    64'(spin_ready_o),   64'd1);
        chk("clr_en",     64'(mux_en_o),       64'd0);
        chk("clr_vld",    64'(energy_valid_o), 64'd0);
        chk("clr_idx",    64'(mux_idx_o),      64'd0);
        chk("clr_data",   64'(mux_data_o),     64'hAA);
        chk("clr_ehold",  64'(energy_o),       64'(last_energy));
        repeat (DW + 2) begin
            @(negedge clk_i);
            chk("clr_novld", 64'(energy_valid_o), 64'd0);
        end
        // Clear beats a simultaneous handshake.
        spin_valid_i = 1'b1;
        spin_i       = 8'h55;
        clear_i      = 1'b1;
        @(negedge clk_i);
        spin_valid_i = 1'b0;
        clear_i      = 1'b0;
        chk("clrpri_en",   64'(mux_en_o),     64'd0);
        chk("clrpri_rdy",  64'(spin_ready_o), 64'd1);
        chk("clrpri_data", 64'(mux_data_o),   64'hAA);
        do_scan(8'h1F, {8{8'h05}}, 12'd10, 0);

        // Asynchronous reset between edges mid-scan.
        @(negedge clk_i);
        spin_valid_i = 1'b1;
        spin_i       = 8'hFF;
        load_w({8{8'h03}});
        @(negedge clk_i);
        spin_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(negedge clk_i);
        rst_i = 1'b0;
        last_energy = '0;

        for (int n = 0; n < 20; n++) begin
            s = DW'($urandom);
            w = {$urandom, $urandom};
            do_scan(s, w, ref_energy(s, w), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
